reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 tb/tb_reorder_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: index-width defaults, the null index,
// the wrap-skipping-zero pointer increment, and the per-entry payload layout.
`ifndef ROB_DEFINES_SV
`define ROB_DEFINES_SV
`define ROB_ENTRY_WIDTH 3
`define ROB_NULL_INDEX 0
// Pointer increment over 1..last: wraps from last back to 1, never to the null index.
`define ROB_PTR_INC(p, last) (((p) == (last)) ? 1 : (p) + 1)
`endif

package reorder_buffer_pkg;

  localparam int ROB_ENTRY_W = `ROB_ENTRY_WIDTH;
  localparam int ROB_NULL    = `ROB_NULL_INDEX;
  localparam int XLEN        = 32;
  localparam int REG_W       = 5;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  data;
    logic             mispredict;
    logic [XLEN-1:0]  target;
  } rob_payload_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates indices to decode, gathers out-of-order
// writebacks, retires in order onto the commit bus, and flushes on a mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_W = ROB_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dst,
  output logic             alloc_ready,
  output logic [ROB_W-1:0] alloc_index,
  input  logic             wb_valid,
  input  logic [ROB_W-1:0] wb_index,
  input  logic [31:0]      wb_data,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  logic [ROB_W-1:0] rd_index1,
  input  logic [ROB_W-1:0] rd_index2,
  output logic             rd_ready1,
  output logic             rd_ready2,
  output logic [31:0]      rd_data1,
  output logic [31:0]      rd_data2,
  output logic             commit_we,
  output logic [4:0]       commit_addr,
  output logic [31:0]      commit_data,
  output logic [ROB_W-1:0] commit_index,
  output logic             rollback,
  output logic [31:0]      redirect_pc,
  output logic [ROB_W-1:0] count
);

  localparam int ENTRIES = 2 ** ROB_W;
  localparam int LAST    = ENTRIES - 1;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] done;
  rob_payload_t       payload [ENTRIES];
  logic [ROB_W-1:0]   head;
  logic [ROB_W-1:0]   tail;

  logic head_valid;
  logic retire;
  logic flush;
  logic alloc_fire;
  logic wb_fire;

  function automatic logic [ROB_W-1:0] inc_ptr(input logic [ROB_W-1:0] p);
    return ROB_W'(`ROB_PTR_INC(int'(p), LAST));
  endfunction

  // Space check uses registered count only; a same-cycle retire does not free a slot.
  assign alloc_ready = (count < ROB_W'(LAST)) && !rollback;
  assign alloc_index = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign head_valid  = valid[head];
  assign retire      = head_valid && done[head];
  assign flush       = retire && payload[head].mispredict;
  assign wb_fire     = wb_valid && !rollback && (wb_index != ROB_W'(ROB_NULL)) && valid[wb_index];

  assign commit_we    = retire && (payload[head].dst != '0);
  assign commit_addr  = head_valid ? payload[head].dst  : '0;
  assign commit_data  = head_valid ? payload[head].data : '0;
  assign commit_index = head_valid ? head : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= '0;
      done        <= '0;
      head        <= ROB_W'(1);
      tail        <= ROB_W'(1);
      count       <= '0;
      rollback    <= 1'b0;
      redirect_pc <= '0;
    end else if (flush) begin
      valid       <= '0;
      done        <= '0;
      head        <= ROB_W'(1);
      tail        <= ROB_W'(1);
      count       <= '0;
      rollback    <= 1'b1;
      redirect_pc <= payload[head].target;
    end else begin
      rollback <= 1'b0;
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= inc_ptr(tail);
      end
      if (wb_fire) begin
        done[wb_index] <= 1'b1;
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= inc_ptr(head);
      end
      case ({alloc_fire, retire})
        2'b10:   count <= count + ROB_W'(1);
        2'b01:   count <= count - ROB_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; valid/done gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      payload[tail].dst <= alloc_dst;
    end
    if (wb_fire) begin
      payload[wb_index].data       <= wb_data;
      payload[wb_index].mispredict <= wb_mispredict;
      payload[wb_index].target     <= wb_target;
    end
  end

  logic [ROB_W-1:0] rd_idx [2];
  logic             rd_rdy [2];
  logic [31:0]      rd_dat [2];
  logic             rd_byp;

  assign rd_idx[0] = rd_index1;
  assign rd_idx[1] = rd_index2;

  // A same-cycle writeback to the looked-up entry is forwarded straight through.
  always_comb begin
    rd_byp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_rdy[i] = 1'b0;
      rd_dat[i] = '0;
      if (rd_idx[i] != ROB_W'(ROB_NULL)) begin
        rd_byp    = wb_valid && (wb_index == rd_idx[i]);
        rd_rdy[i] = valid[rd_idx[i]] && (done[rd_idx[i]] || rd_byp);
        rd_dat[i] = rd_byp ? wb_data : payload[rd_idx[i]].data;
      end
    end
  end

  assign rd_ready1 = rd_rdy[0];
  assign rd_ready2 = rd_rdy[1];
  assign rd_data1  = rd_dat[0];
  assign rd_data2  = rd_dat[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based program-order model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_reorder_buffer;

  localparam int W   = 3;
  localparam int CAP = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic [4:0]    alloc_dst = '0;
  logic          alloc_ready;
  logic [W-1:0]  alloc_index;
  logic          wb_valid = 1'b0;
  logic [W-1:0]  wb_index = '0;
  logic [31:0]   wb_data = '0;
  logic          wb_mispredict = 1'b0;
  logic [31:0]   wb_target = '0;
  logic [W-1:0]  rd_index1 = '0;
  logic [W-1:0]  rd_index2 = '0;
  logic          rd_ready1, rd_ready2;
  logic [31:0]   rd_data1, rd_data2;
  logic          commit_we;
  logic [4:0]    commit_addr;
  logic [31:0]   commit_data;
  logic [W-1:0]  commit_index;
  logic          rollback;
  logic [31:0]   redirect_pc;
  logic [W-1:0]  count;

  reorder_buffer #(.ROB_W(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dst(alloc_dst),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .rd_index1(rd_index1), .rd_index2(rd_index2),
    .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .commit_we(commit_we), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_index(commit_index),
    .rollback(rollback), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: queue front is the oldest in-flight instruction.
  typedef struct {
    logic [W-1:0] idx;
    logic [4:0]   dst;
    bit           done;
    logic [31:0]  data;
    bit           misp;
    logic [31:0]  tgt;
  } ent_t;

  ent_t        q[$];
  int          m_tail = 1;
  bit          m_rb = 1'b0;
  logic [31:0] m_rpc = '0;

  function automatic int find(input logic [W-1:0] idx);
    for (int i = 0; i < q.size(); i++) if (q[i].idx == idx) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 1;
    m_rb   = 1'b0;
    m_rpc  = '0;
  endtask

  task automatic check_rd(input string name, input logic [W-1:0] idx,
                          input logic rdy, input logic [31:0] dat);
    int  p;
    bit  byp;
    bit  exp_rdy;
    p = find(idx);
    byp = wb_valid && (wb_index == idx);
    exp_rdy = (idx != 0) && (p >= 0) && (q[p].done || byp);
    check({name, "_ready"}, 32'(rdy), 32'(exp_rdy));
    if (idx == 0) check({name, "_data"}, dat, 32'h0);
    else if (exp_rdy) check({name, "_data"}, dat, byp ? wb_data : q[p].data);
  endtask

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      check("count", 32'(count), 32'(q.size()));
      check("alloc_ready", 32'(alloc_ready), 32'((q.size() < CAP) && !m_rb));
      check("alloc_index", 32'(alloc_index), 32'(m_tail));
      check("rollback", 32'(rollback), 32'(m_rb));
      if (m_rb) check("redirect_pc", redirect_pc, m_rpc);
      if (q.size() > 0) begin
        check("commit_index", 32'(commit_index), 32'(q[0].idx));
        check("commit_addr", 32'(commit_addr), 32'(q[0].dst));
        check("commit_we", 32'(commit_we), 32'(q[0].done && (q[0].dst != 0)));
        if (q[0].done) check("commit_data", commit_data, q[0].data);
      end else begin
        check("commit_index", 32'(commit_index), 32'h0);
        check("commit_addr", 32'(commit_addr), 32'h0);
        check("commit_data", commit_data, 32'h0);
        check("commit_we", 32'(commit_we), 32'h0);
      end
      check_rd("rd1", rd_index1, rd_ready1, rd_data1);
      check_rd("rd2", rd_index2, rd_ready2, rd_data2);

      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        bit retire;
        bit flush;
        bit alloc;
        int p;
        ent_t e;
        retire = (q.size() > 0) && q[0].done;
        flush  = retire && q[0].misp;
        alloc  = alloc_valid && (q.size() < CAP) && !m_rb;
        if (flush) begin
          m_rpc = q[0].tgt;
          q.delete();
          m_tail = 1;
          m_rb = 1'b1;
        end else begin
          m_rb = 1'b0;
          if (wb_valid) begin
            p = find(wb_index);
            if (p >= 0) begin
              e = q[p];
              e.done = 1'b1;
              e.data = wb_data;
              e.misp = wb_mispredict;
              e.tgt  = wb_target;
              q[p] = e;
            end
          end
          if (retire) void'(q.pop_front());
          if (alloc) begin
            e.idx = W'(m_tail);
            e.dst = alloc_dst;
            e.done = 1'b0;
            e.data = '0;
            e.misp = 1'b0;
            e.tgt = '0;
            q.push_back(e);
            m_tail = (m_tail == CAP) ? 1 : m_tail + 1;
          end
        end
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_dst = '0;
    wb_valid = 1'b0;
    wb_index = '0;
    wb_data = '0;
    wb_mispredict = 1'b0;
    wb_target = '0;
  endtask

  task automatic alloc(input logic [4:0] dst);
    idle();
    alloc_valid = 1'b1;
    alloc_dst = dst;
  endtask

  task automatic wb(input logic [W-1:0] idx, input logic [31:0] data,
                    input logic misp, input logic [31:0] tgt);
    idle();
    wb_valid = 1'b1;
    wb_index = idx;
    wb_data = data;
    wb_mispredict = misp;
    wb_target = tgt;
  endtask

  task automatic reset_dut();
    go();
    idle();
    rst = 1'b1;
    go();
    rst = 1'b0;
  endtask

  task automatic check_commit(input string name, input logic we, input logic [4:0] addr,
                              input logic [31:0] data, input logic [W-1:0] idx);
    check({name, "_we"}, 32'(commit_we), 32'(we));
    check({name, "_addr"}, 32'(commit_addr), 32'(addr));
    check({name, "_data"}, commit_data, data);
    check({name, "_index"}, 32'(commit_index), 32'(idx));
  endtask

  initial begin : stimulus
    rd_index1 = 3'd1;
    go();
    check("rst_alloc_ready", 32'(alloc_ready), 32'h1);
    check("rst_alloc_index", 32'(alloc_index), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_commit_we", 32'(commit_we), 32'h0);
    check("rst_rollback", 32'(rollback), 32'h0);
    check("rst_rd_ready1", 32'(rd_ready1), 32'h0);
    rst = 1'b0;

    // In-order retirement of out-of-order completions.
    go(); alloc(5'd5); #1 check("t1_idx1", 32'(alloc_index), 32'h1);
    go(); alloc(5'd6); #1 check("t1_idx2", 32'(alloc_index), 32'h2);
    go(); alloc(5'd7); #1 check("t1_idx3", 32'(alloc_index), 32'h3);
    go(); idle(); #1;
    check("t1_count3", 32'(count), 32'h3);
    check("t1_no_commit", 32'(commit_we), 32'h0);
    go(); wb(3'd3, 32'h33, 1'b0, 32'h0);
    go(); wb(3'd1, 32'h11, 1'b0, 32'h0); #1 check("t1_wait", 32'(commit_we), 32'h0);
    go(); wb(3'd2, 32'h22, 1'b0, 32'h0); #1 check_commit("t1_c1", 1'b1, 5'd5, 32'h11, 3'd1);
    go(); idle(); #1 check_commit("t1_c2", 1'b1, 5'd6, 32'h22, 3'd2);
    go(); #1 check_commit("t1_c3", 1'b1, 5'd7, 32'h33, 3'd3);
    go(); #1 check("t1_drained", 32'(count), 32'h0);

    // Fill to capacity, then free one slot and see the tail wrap to index 1.
    reset_dut();
    for (int i = 0; i < CAP; i++) begin
      go(); alloc(5'(i + 1));
    end
    go(); alloc(5'd20); #1;
    check("full_ready", 32'(alloc_ready), 32'h0);
    check("full_count", 32'(count), 32'h7);
    check("full_index", 32'(alloc_index), 32'h1);
    go(); wb(3'd1, 32'h1, 1'b0, 32'h0);
    go(); idle(); #1;
    check("full_commit_idx", 32'(commit_index), 32'h1);
    check("full_ready_held", 32'(alloc_ready), 32'h0);
    go(); #1;
    check("wrap_count", 32'(count), 32'h6);
    check("wrap_ready", 32'(alloc_ready), 32'h1);
    check("wrap_index", 32'(alloc_index), 32'h1);
    alloc(5'd9);
    go(); idle(); #1;
    check("wrap_next_index", 32'(alloc_index), 32'h2);
    check("wrap_refull", 32'(alloc_ready), 32'h0);

    // Destination x0 retires without a register write.
    reset_dut();
    go(); alloc(5'd0);
    go(); wb(3'd1, 32'h55, 1'b0, 32'h0);
    go(); idle(); #1 check_commit("x0", 1'b0, 5'd0, 32'h55, 3'd1);
    go(); #1;
    check("x0_count", 32'(count), 32'h0);
    check("x0_head_moved", 32'(commit_index), 32'h0);
    check("x0_next_index", 32'(alloc_index), 32'h2);

    // Mispredicted branch retire, flush, one-cycle rollback.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      go(); alloc(5'(i + 1));
    end
    go(); wb(3'd1, 32'h99, 1'b1, 32'h80);
    go(); alloc(5'd10); #1;
    check_commit("mp_commit", 1'b1, 5'd1, 32'h99, 3'd1);
    go(); alloc(5'd11); wb_valid = 1'b1; wb_index = 3'd2; wb_data = 32'h22; #1;
    check("mp_rollback", 32'(rollback), 32'h1);
    check("mp_redirect", redirect_pc, 32'h80);
    check("mp_count", 32'(count), 32'h0);
    check("mp_alloc_blocked", 32'(alloc_ready), 32'h0);
    go(); idle(); #1;
    check("mp_rollback_done", 32'(rollback), 32'h0);
    check("mp_count_after", 32'(count), 32'h0);
    check("mp_alloc_index", 32'(alloc_index), 32'h1);
    go(); alloc(5'd12); #1 check("mp_realloc", 32'(alloc_index), 32'h1);
    go(); idle(); #1 check("mp_realloc_count", 32'(count), 32'h1);

    // Operand read with same-cycle writeback forwarding.
    reset_dut();
    go(); alloc(5'd3);
    go(); alloc(5'd4);
    go(); wb(3'd2, 32'hAB, 1'b0, 32'h0); rd_index1 = 3'd2; rd_index2 = 3'd1; #1;
    check("byp_ready1", 32'(rd_ready1), 32'h1);
    check("byp_data1", rd_data1, 32'hAB);
    check("byp_ready2", 32'(rd_ready2), 32'h0);
    go(); idle(); rd_index2 = 3'd0; #1;
    check("stored_ready1", 32'(rd_ready1), 32'h1);
    check("stored_data1", rd_data1, 32'hAB);
    check("null_ready2", 32'(rd_ready2), 32'h0);
    check("null_data2", rd_data2, 32'h0);

    // Asynchronous reset with four entries in flight.
    go(); alloc(5'd8);
    go(); alloc(5'd9);
    go(); idle(); #1 check("pre_rst_count", 32'(count), 32'h4);
    go(); rst = 1'b1; #1;
    check("arst_count", 32'(count), 32'h0);
    check("arst_ready", 32'(alloc_ready), 32'h1);
    check("arst_index", 32'(alloc_index), 32'h1);
    check("arst_commit_we", 32'(commit_we), 32'h0);
    check("arst_rd_ready1", 32'(rd_ready1), 32'h0);
    go(); rst = 1'b0;
    go();
    go();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
